// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - five-state IF/ID/EX/MEM/WB control unit for the multicycle RV32I subset
module multicycle_control #(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 zero,
    output logic                 loadPC,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemToReg,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_ILL
    } class_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    function automatic class_e classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = CL_R;
            7'b0010011: classify = CL_I;
            7'b0000011: classify = CL_LW;
            7'b0100011: classify = CL_SW;
            7'b1100011: classify = CL_BEQ;
            default:    classify = CL_ILL;
        endcase
    endfunction

    state_e      state_q;
    logic [31:0] instr_q;
    logic        zero_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        reg_write_q;
    logic        load_pc_q;
    logic        pc_src_q;
    logic        illegal_q;

    class_e      cls;
    logic [3:0]  alu_op;
    logic        decoded;

    // Only opcode, funct3 and bit30 steer the control; the rest belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

    always_comb begin
        cls     = classify(instr_q[6:0]);
        alu_op  = ALU_ADD;
        decoded = (state_q == S_ID) || (state_q == S_EX) ||
                  (state_q == S_MEM) || (state_q == S_WB);
        if (cls == CL_R || cls == CL_I) begin
            case (instr_q[14:12])
                3'b000:  alu_op = (cls == CL_R && instr_q[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = instr_q[30] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                3'b111:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end else if (cls == CL_BEQ) begin
            alu_op = ALU_SUB;
        end
        ALUSrc   = decoded && (cls == CL_I || cls == CL_LW || cls == CL_SW);
        MemToReg = decoded && (cls == CL_LW);
        ALUCtrl  = decoded ? ALUCTRL_W'(alu_op) : '0;
    end

    // Strobes are registered one state early so they appear as clean single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IF;
            instr_q     <= '0;
            zero_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            load_pc_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            mem_read_q  <= (state_q == S_EX) && (cls == CL_LW);
            mem_write_q <= (state_q == S_EX) && (cls == CL_SW);
            reg_write_q <= (state_q == S_MEM) && (cls == CL_R || cls == CL_I || cls == CL_LW);
            load_pc_q   <= (state_q == S_MEM);
            pc_src_q    <= (state_q == S_MEM) && (cls == CL_BEQ) && zero_q;
            case (state_q)
                S_IF: begin
                    state_q   <= S_ID;
                    instr_q   <= instr;
                    illegal_q <= (classify(instr[6:0]) == CL_ILL);
                end
                S_ID:  state_q <= S_EX;
                S_EX: begin
                    state_q <= S_MEM;
                    zero_q  <= zero;
                end
                S_MEM: state_q <= S_WB;
                default: begin
                    state_q   <= S_IF;
                    illegal_q <= 1'b0;
                end
            endcase
        end
    end

    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign RegWrite = reg_write_q;
    assign loadPC   = load_pc_q;
    assign PCSrc    = pc_src_q;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and random instruction sequences against a per-cycle reference model
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        loadPC, PCSrc, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    multicycle_control #(.ALUCTRL_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {state, loadPC, PCSrc, ALUSrc, ALUCtrl, MemRead, MemWrite, MemToReg, RegWrite, illegal};

    // In ID the operand/ALU decode is not checked; illegal is.
    localparam logic [14:0] MASK_ID  = 15'h7C1B;
    localparam logic [14:0] MASK_ALL = 15'h7FFF;

    logic [3:0] f3_tab [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b0010,
                               4'b1101, 4'b1000, 4'b0001, 4'b0000};

    function automatic logic [14:0] model(input logic [31:0] w, input logic z, input int c);
        logic r, i, lw, sw, beq, ill, dec;
        logic [3:0] alu;
        r   = (w[6:0] == 7'h33);
        i   = (w[6:0] == 7'h13);
        lw  = (w[6:0] == 7'h03);
        sw  = (w[6:0] == 7'h23);
        beq = (w[6:0] == 7'h63);
        ill = !(r || i || lw || sw || beq);
        if (r || i) begin
            alu = f3_tab[w[14:12]];
            if (w[14:12] == 3'd0 && r && w[30]) alu = 4'b0110;
            if (w[14:12] == 3'd5 && w[30])      alu = 4'b1010;
        end else begin
            alu = beq ? 4'b0110 : 4'b0010;
        end
        dec = (c >= 1);
        return {3'(c), c == 4, c == 4 && beq && z, dec && (i || lw || sw),
                dec ? alu : 4'b0000, c == 3 && lw, c == 3 && sw, dec && lw,
                c == 4 && (r || i || lw), dec && ill};
    endfunction

    task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e, input logic [14:0] m);
        tests++;
        assert ((o & m) === (e & m)) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, o, e, m);
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                             input bit chg, input int abort_c);
        instr = ins;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("%s_c%0d", tag, c), obs, model(ins, z, c), (c == 1) ? MASK_ID : MASK_ALL);
            if (c == abort_c) begin
                #1 rst = 1'b1;
                #1 check({tag, "_rst_async"}, obs, 15'h0, MASK_ALL);
                @(negedge clk);
                check({tag, "_rst_held"}, obs, 15'h0, MASK_ALL);
                rst = 1'b0;
                return;
            end
            zero = (c == 2) ? z : 1'($urandom_range(0, 1));
            if (chg && c >= 1) instr = $urandom;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] w;
        int k;
        @(negedge clk);
        check("reset_1", obs, 15'h0, MASK_ALL);
        @(negedge clk);
        check("reset_2", obs, 15'h0, MASK_ALL);
        rst = 1'b0;

        run_instr("add",     32'h002081B3, 1'b0, 1'b0, -1);
        run_instr("sub",     32'h402081B3, 1'b1, 1'b0, -1);
        run_instr("lw",      32'h00802283, 1'b0, 1'b0, -1);
        run_instr("sw",      32'h00502623, 1'b0, 1'b0, -1);
        run_instr("beq_z1",  32'h00000463, 1'b1, 1'b0, -1);
        run_instr("beq_z0",  32'h00000463, 1'b0, 1'b0, -1);
        run_instr("illegal", 32'h0000007F, 1'b1, 1'b0, -1);
        run_instr("sw_abort",32'h00502623, 1'b0, 1'b0, 3);
        run_instr("add_chg", 32'h002081B3, 1'b0, 1'b1, -1);
        run_instr("sra_i",   32'h4030D093, 1'b0, 1'b1, -1);

        for (int n = 0; n < 30; n++) begin
            w = $urandom;
            k = $urandom_range(0, 5);
            case (k)
                0: w[6:0] = 7'h33;
                1: w[6:0] = 7'h13;
                2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;
                4: w[6:0] = 7'h63;
                default: ;
            endcase
            if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && w[14:12] == 3'b011) w[14:12] = 3'b000;
            run_instr($sformatf("rnd%0d", n), w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle RV32I-subset processor: 5-state FSM sequencing IF, ID, EX, MEM, WB.
- Decodes the fetched instruction into datapath strobes and the ALU operation code.
- Sits directly upstream of the datapath inside the processor top: it drives PC load/select, ALU source, memory read/write and register write-back.
- Every instruction takes exactly 5 clocks.

Parameters:
- ALUCTRL_W, 4, width of the ALU operation code.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction word from instruction memory; valid in IF.
- zero  input  1  ALU zero flag from datapath; valid in EX.
- loadPC  output  1  PC register load enable.
- PCSrc  output  1  0 = PC+4, 1 = PC+branch offset.
- ALUSrc  output  1  0 = rs2 operand, 1 = immediate operand.
- ALUCtrl  output  ALUCTRL_W  ALU operation code.
- MemRead  output  1  data memory read strobe.
- MemWrite  output  1  data memory write enable.
- MemToReg  output  1  write-back source: 0 = ALU, 1 = memory.
- RegWrite  output  1  register file write enable.
- illegal  output  1  unsupported opcode flag.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset: asynchronous, active-high. The FSM goes immediately to IF (3'd0), `instr_q` and `zero_q` clear to 0, and all outputs are 0.
- Reset asserted mid-instruction aborts the instruction: no MemWrite, RegWrite or loadPC is produced after rst rises.
- States and transitions (unconditional on every clock): IF(0) -> ID(1) -> EX(2) -> MEM(3) -> WB(4) -> IF. Encodings 5-7 are unreachable and recover to IF on the next clock.
- On IF->ID, `instr` is latched into `instr_q`. All decoding uses `instr_q`, so instruction memory may change after IF.
- On EX->MEM, `zero` is latched into `zero_q`.
- Decoded classes on `instr_q[6:0]`:
  - R-type 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ 1100011.
  - Any other opcode is illegal.
- ALUSrc (combinational from `instr_q`, all states after ID): 1 for I-ALU, LW, SW; 0 otherwise.
- MemToReg (combinational from `instr_q`, all states after ID): 1 for LW only.
- ALUCtrl (combinational from `instr_q`, all states after ID):
  - Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - R-type: selected from funct3 / `instr_q[30]`. funct3=000 gives SUB if bit30=1, else ADD; 001 SLL; 010 SLT; 100 XOR; 101 SRA if bit30=1, else SRL; 110 OR; 111 AND.
  - I-ALU: same mapping, except funct3=000 is always ADD. Bit30 is used only for funct3=101.
  - LW and SW: ADD. BEQ: SUB. Illegal: ADD.
- MemRead = 1 only in MEM when class is LW.
- MemWrite = 1 only in MEM when class is SW.
- RegWrite = 1 only in WB when class is R-type, I-ALU or LW.
- loadPC = 1 only in WB, for every class including illegal. Exactly one PC update per 5 clocks.
- PCSrc = 1 only in WB when class is BEQ and `zero_q` = 1; otherwise 0.
- illegal = 1 in ID through WB when the opcode is unsupported. While illegal is set, no MemRead, MemWrite or RegWrite is asserted; the PC advances by PC+4.
- Strobes are single-cycle pulses. No two of MemRead, MemWrite and RegWrite are ever high in the same cycle.
- `state` output equals the FSM register.

Test Plan:
- Reset: hold rst for 2 clocks, then release → state=0 and all outputs 0 throughout reset. state sequence 0,1,2,3,4,0 on the following clocks.
- add x3,x1,x2 (0x002081B3) → ALUCtrl=0010, ALUSrc=0. RegWrite=1 and loadPC=1 only in state 4. MemRead/MemWrite never 1.
- sub x3,x1,x2 (0x402081B3) → ALUCtrl=0110.
- lw x5,8(x0) (0x00802283) → ALUSrc=1, ALUCtrl=0010, MemToReg=1. MemRead=1 in state 3 only; RegWrite=1 in state 4 only.
- sw x5,12(x0) (0x00502623) → MemWrite=1 in state 3 only, RegWrite never 1.
- beq x0,x0,8 (0x00000463) with zero=1 in EX → PCSrc=1 and loadPC=1 in WB. Repeat with zero=0 → PCSrc=0, loadPC=1.
- Illegal opcode 0x0000007F → illegal=1 in states 1-4, no memory/register strobes, loadPC=1 with PCSrc=0.
- Reset asserted mid-instruction: assert rst while in MEM of an SW → MemWrite drops to 0 immediately and state=0 without waiting for a clock edge.
- Instruction changed after IF: change `instr` after IF → outputs still follow the latched instruction.
